fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  Pointer/flag controller driving the 8x16 FIFO memory's AddrWrite, AddrRead, WE and OE.
//  Turns producer Push and consumer Pop requests into memory addresses and write strobes.
//  Presents first-word-fall-through status: DataOut at AddrRead is valid whenever Empty=0.
//  Sits between the CAVLC coefficient producer and the bitstream packer.
// PARAMETERS
//  ADDR_W   3           memory address width; DEPTH = 1<<ADDR_W entries (8 default)
// PORTS
//  Clk        in   1         system clock, all state on rising edge
//  nReset     in   1         asynchronous active-low reset
//  Push       in   1         producer requests write of current DataIn this cycle
//  Pop        in   1         consumer consumes head word this cycle
//  Flush      in   1         synchronous clear of pointers/count
//  AddrWrite  out  ADDR_W    write address to memory (= wr_ptr[ADDR_W-1:0])
//  AddrRead   out  ADDR_W    read address to memory (= rd_ptr[ADDR_W-1:0])
//  WE         out  1         memory write enable, combinational = accepted push
//  OE         out  1         memory read enable = ~Empty
//  Full       out  1         Count == DEPTH
//  Empty      out  1         Count == 0
//  Count      out  ADDR_W+1  words held, 0..DEPTH
//  Overflow   out  1         [FIFO_CTRL_ERR_EN only] sticky: push refused while full
//  Underflow  out  1         [FIFO_CTRL_ERR_EN only] sticky: pop refused while empty
// BEHAVIOUR
//  - Reset (async, nReset=0): wr_ptr=rd_ptr=0 (ADDR_W+1 bits incl. wrap bit), Count=0,
//    Empty=1, Full=0, WE=0, OE=0, AddrWrite=AddrRead=0, Overflow=Underflow=0.
//  - push_ok = Push & ~Flush & (~Full | Pop);  pop_ok = Pop & ~Flush & ~Empty.
//  - WE = push_ok (combinational); memory captures DataIn at AddrWrite on same edge.
//  - Edge: wr_ptr += push_ok; rd_ptr += pop_ok; Count += push_ok - pop_ok.
//  - Pointers wrap modulo 2*DEPTH; Full = (addr bits equal, wrap bits differ).
//  - Empty = (wr_ptr == rd_ptr); Count = wr_ptr - rd_ptr (ADDR_W+1 bits, no saturation needed).
//  - Latency: word pushed at edge N is visible at DataOut, Empty=0, from cycle N+1.
//  - Full & Push & Pop: both accepted. Head is read combinationally before the edge;
//    the write lands in the freed slot. Count stays DEPTH.
//  - Empty & Push & Pop: push accepted, pop refused. Count becomes 1.
//  - Full & Push & ~Pop: push refused, WE=0, no state change.
//  - Empty & Pop: ignored.
//  - Flush: highest priority. Next edge pointers=0, Count=0, WE=0; sticky flags cleared.
//  - Reset mid-operation discards all contents; memory contents are don't-care afterwards.
//  - No FSM. State is two pointer counters; flags are decoded from them, registered-equivalent.
// CONFIGURATION
//  FIFO_CTRL_ERR_EN defined:
//   - Overflow sets on Push & Full & ~Pop & ~Flush.
//   - Underflow sets on Pop & Empty & ~Push... (and on Pop & Empty generally) & ~Flush.
//   - Both hold until Flush or reset.
//  FIFO_CTRL_ERR_EN undefined:
//   - Ports Overflow/Underflow and their logic are absent.
//   - Refused requests are silently dropped.
// STRUCTURE
//  - Shared package cavlc_fifo_pkg: FIFO_ADDR_W=3, FIFO_DATA_W=16 and FIFO_DEPTH localparams.
//    The memory and this controller both use them.
//  - Sub-module fifo_ptr (ADDR_W+1-bit wrap counter with inc and clr), instanced for wr and rd.
//  - Flag decode and push_ok/pop_ok gating live in fifo_ctrl top.
// TESTING (bench instantiates fifo_ctrl + FIFO memory, scoreboard model)
//  1. Reset, then push 8 words 0x1000..0x1007:
//     -> Full=1, Count=8, AddrWrite wraps to 0; 9th push WE=0 (Overflow=1 if ERR_EN).
//  2. Pop 8 times from full:
//     -> DataOut sequence 0x1000..0x1007, Empty=1 after 8th edge; 9th pop no change.
//  3. At Count=8, Push=Pop=1 with DataIn=0xBEEF:
//     -> head popped, Count=8, 0xBEEF read out 8 pops later.
//  4. Empty, Push=Pop=1 with DataIn=0x00AA:
//     -> Count=1, DataOut=0x00AA next cycle, rd_ptr unchanged.
//  5. Count=5, assert Flush with Push=1:
//     -> next cycle Count=0, Empty=1, WE=0 during Flush, pointers 0.
//  6. Assert nReset=0 asynchronously mid-burst at Count=3:
//     -> all outputs at reset values immediately, without waiting for a clock.

Source files
------------

// File: rtl/cavlc_fifo_pkg.sv
// Shared sizing for the CAVLC coefficient FIFO: the 8x16 memory and its
// pointer/flag controller both take their widths from here so they cannot drift.
package cavlc_fifo_pkg;

    localparam int FIFO_ADDR_W = 3;
    localparam int FIFO_DATA_W = 16;
    localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer counter for the FIFO controller. One instance tracks the
// write side and one the read side; the extra MSB distinguishes a full
// FIFO from an empty one when the address bits coincide.
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    // Clear wins over increment so a flush always lands the pointer on zero.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the CAVLC coefficient FIFO memory.
// Converts producer Push and consumer Pop requests into memory addresses,
// a write strobe and first-word-fall-through status flags.
// Optional macro FIFO_CTRL_ERR_EN adds sticky Overflow/Underflow outputs;
// without it, refused requests are simply dropped.
module fifo_ctrl
    import cavlc_fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Push,
    input  logic              Pop,
    input  logic              Flush,
    output logic [ADDR_W-1:0] AddrWrite,
    output logic [ADDR_W-1:0] AddrRead,
    output logic              WE,
    output logic              OE,
    output logic              Full,
    output logic              Empty,
    output logic [ADDR_W:0]   Count
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic              Overflow,
    output logic              Underflow
`endif
);

    logic [ADDR_W:0] wrPtr;
    logic [ADDR_W:0] rdPtr;
    logic            pushOk;
    logic            popOk;

    fifo_ptr #(.W(ADDR_W + 1)) wrPtrInst (
        .Clk    (Clk),
        .nReset (nReset),
        .inc    (pushOk),
        .clr    (Flush),
        .ptr    (wrPtr)
    );

    fifo_ptr #(.W(ADDR_W + 1)) rdPtrInst (
        .Clk    (Clk),
        .nReset (nReset),
        .inc    (popOk),
        .clr    (Flush),
        .ptr    (rdPtr)
    );

    // Flags decoded straight from the pointer registers; a full FIFO can still
    // take a push when the head leaves on the same edge, since the freed slot
    // is exactly the one being written.
    always_comb begin
        Empty     = (wrPtr == rdPtr);
        Full      = (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]) &&
                    (wrPtr[ADDR_W] != rdPtr[ADDR_W]);
        Count     = wrPtr - rdPtr;
        AddrWrite = wrPtr[ADDR_W-1:0];
        AddrRead  = rdPtr[ADDR_W-1:0];
        pushOk    = Push & ~Flush & (~Full | Pop);
        popOk     = Pop & ~Flush & ~Empty;
        WE        = pushOk & nReset;
        OE        = ~Empty;
    end

`ifdef FIFO_CTRL_ERR_EN
    // Sticky error flags record any refused request until software flushes.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else if (Flush) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (Push && Full && !Pop) begin
                Overflow <= 1'b1;
            end
            if (Pop && Empty) begin
                Underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural 8x16 memory attached.
// A queue scoreboard holds every accepted word; pops compare DataOut with its head.
module tb_fifo_ctrl;
    import cavlc_fifo_pkg::*;

    logic                   Clk = 1'b0;
    logic                   nReset;
    logic                   Push;
    logic                   Pop;
    logic                   Flush;
    logic [FIFO_ADDR_W-1:0] AddrWrite;
    logic [FIFO_ADDR_W-1:0] AddrRead;
    logic                   WE;
    logic                   OE;
    logic                   Full;
    logic                   Empty;
    logic [FIFO_ADDR_W:0]   Count;
`ifdef FIFO_CTRL_ERR_EN
    logic                   Overflow;
    logic                   Underflow;
    logic                   modelOvf;
    logic                   modelUnf;
`endif

    logic [FIFO_DATA_W-1:0] DataIn;
    logic [FIFO_DATA_W-1:0] DataOut;
    logic [FIFO_DATA_W-1:0] mem [FIFO_DEPTH];

    logic [FIFO_DATA_W-1:0] sb [$];
    int                     modelWr;
    int                     modelRd;
    int                     testsRun;
    int                     failCount;

    fifo_ctrl dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .Push      (Push),
        .Pop       (Pop),
        .Flush     (Flush),
        .AddrWrite (AddrWrite),
        .AddrRead  (AddrRead),
        .WE        (WE),
        .OE        (OE),
        .Full      (Full),
        .Empty     (Empty),
        .Count     (Count)
`ifdef FIFO_CTRL_ERR_EN
        ,
        .Overflow  (Overflow),
        .Underflow (Underflow)
`endif
    );

    always #5 Clk = ~Clk;

    // Behavioural memory: synchronous write, combinational read.
    always @(posedge Clk) begin
        if (WE) mem[AddrWrite] <= DataIn;
    end
    assign DataOut = mem[AddrRead];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every status output against the model's pointers and queue.
    task automatic checkState(input string tag);
        int n;
        n = sb.size();
        checkOutput({tag, " Count"}, Count, n);
        checkOutput({tag, " Empty"}, Empty, (n == 0));
        checkOutput({tag, " Full"}, Full, (n == FIFO_DEPTH));
        checkOutput({tag, " OE"}, OE, (n != 0));
        checkOutput({tag, " AddrWrite"}, AddrWrite, modelWr % FIFO_DEPTH);
        checkOutput({tag, " AddrRead"}, AddrRead, modelRd % FIFO_DEPTH);
`ifdef FIFO_CTRL_ERR_EN
        checkOutput({tag, " Overflow"}, Overflow, modelOvf);
        checkOutput({tag, " Underflow"}, Underflow, modelUnf);
`endif
    endtask

    // One clock of stimulus: drive at the falling edge, check combinational
    // outputs before the rising edge, then update the model and check state.
    task automatic applyStimulus(input string tag, input logic p, input logic q,
                                 input logic f, input logic [15:0] d);
        logic expPushOk;
        logic expPopOk;
        logic [15:0] expHead;
        @(negedge Clk);
        Push = p; Pop = q; Flush = f; DataIn = d;
        #1;
        expPushOk = p & ~f & ((sb.size() < FIFO_DEPTH) | q);
        expPopOk  = q & ~f & (sb.size() > 0);
        checkOutput({tag, " WE"}, WE, expPushOk);
        if (expPopOk) begin
            expHead = sb.pop_front();
            checkOutput({tag, " DataOut"}, DataOut, expHead);
        end
        if (expPushOk) sb.push_back(d);
`ifdef FIFO_CTRL_ERR_EN
        if (f) begin
            modelOvf = 1'b0;
            modelUnf = 1'b0;
        end else begin
            if (p && !q && !expPushOk) modelOvf = 1'b1;
            if (q && !expPopOk) modelUnf = 1'b1;
        end
`endif
        if (f) begin
            sb.delete();
            modelWr = 0;
            modelRd = 0;
        end else begin
            modelWr = (modelWr + int'(expPushOk)) % (2 * FIFO_DEPTH);
            modelRd = (modelRd + int'(expPopOk)) % (2 * FIFO_DEPTH);
        end
        @(posedge Clk);
        #1;
        checkState(tag);
    endtask

    task automatic modelReset();
        sb.delete();
        modelWr = 0;
        modelRd = 0;
`ifdef FIFO_CTRL_ERR_EN
        modelOvf = 1'b0;
        modelUnf = 1'b0;
`endif
    endtask

    initial begin
        testsRun = 0;
        failCount = 0;
        Push = 0; Pop = 0; Flush = 0; DataIn = '0;
        modelReset();
        nReset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkState("reset");
        checkOutput("reset WE", WE, 0);
        @(negedge Clk);
        nReset = 1'b1;

        // Fill to full, then one refused push.
        for (int i = 0; i < 8; i++) applyStimulus("fill", 1, 0, 0, 16'h1000 + 16'(i));
        checkOutput("fill Full", Full, 1);
        checkOutput("fill AddrWrite wrap", AddrWrite, 0);
        applyStimulus("push when full", 1, 0, 0, 16'h1008);

        // Drain in order, then one ignored pop.
        for (int i = 0; i < 8; i++) applyStimulus("drain", 0, 1, 0, 16'h0);
        checkOutput("drain Empty", Empty, 1);
        applyStimulus("pop when empty", 0, 1, 0, 16'h0);

        // Simultaneous push/pop at full: BEEF must come out last.
        for (int i = 0; i < 8; i++) applyStimulus("refill", 1, 0, 0, 16'h2000 + 16'(i));
        applyStimulus("full push pop", 1, 1, 0, 16'hBEEF);
        checkOutput("full push pop Count", Count, 8);
        for (int i = 0; i < 8; i++) applyStimulus("drain2", 0, 1, 0, 16'h0);

        // Simultaneous push/pop at empty: only the push is taken.
        applyStimulus("empty push pop", 1, 1, 0, 16'h00AA);
        checkOutput("empty push pop DataOut", DataOut, 16'h00AA);
        checkOutput("empty push pop AddrRead", AddrRead, modelRd % FIFO_DEPTH);
        applyStimulus("pop AA", 0, 1, 0, 16'h0);

        // Flush beats a concurrent push.
        for (int i = 0; i < 5; i++) applyStimulus("pre flush", 1, 0, 0, 16'h3000 + 16'(i));
        applyStimulus("flush", 1, 0, 1, 16'h3005);
        checkOutput("flush AddrWrite", AddrWrite, 0);
        applyStimulus("after flush", 1, 0, 0, 16'h4000);
        applyStimulus("after flush pop", 0, 1, 0, 16'h0);

        // Asynchronous reset mid-burst, checked before any clock edge.
        for (int i = 0; i < 3; i++) applyStimulus("pre reset", 1, 0, 0, 16'h5000 + 16'(i));
        @(negedge Clk);
        Push = 1; DataIn = 16'h5003;
        #2;
        nReset = 1'b0;
        #1;
        modelReset();
        checkState("async reset");
        checkOutput("async reset WE", WE, 0);
        Push = 0;
        @(negedge Clk);
        nReset = 1'b1;
        applyStimulus("post reset push", 1, 0, 0, 16'h6000);
        applyStimulus("post reset pop", 0, 1, 0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
